// File: rtl/sprite_frame_reader.sv
// rtl/sprite_frame_reader.sv - sprite sheet frame fetcher feeding a valid/ready pixel stream
// Absorbs the 1-cycle RAM read latency with credit-limited issue into a 2-entry output FIFO.
module sprite_frame_reader #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 4,
  parameter int FRAME_W    = 32,
  parameter int FRAME_H    = 32,
  parameter int SHEET_W    = 800,
  parameter int NUM_FRAMES = 25,
  parameter int TRANSP     = 0,
  localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [5:0]        i_frame_idx,
  input  logic              i_hflip,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_read_address,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic [DATA_W-1:0] o_pix_data,
  output logic [XW-1:0]     o_pix_x,
  output logic [YW-1:0]     o_pix_y,
  output logic              o_pix_opaque,
  output logic              o_pix_valid,
  input  logic              i_pix_ready
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  localparam logic [5:0]        LAST_F   = 6'(NUM_FRAMES - 1);
  localparam logic [XW-1:0]     COL_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0]     ROW_LAST = YW'(FRAME_H - 1);
  localparam logic [ADDR_W-1:0] SHEET    = ADDR_W'(SHEET_W);
  localparam logic [DATA_W-1:0] TRANSP_V = DATA_W'(TRANSP);

  state_t              r_state;
  logic                r_busy, r_done, r_hflip, r_inflight;
  logic [ADDR_W-1:0]   r_addr, r_base, r_row_off;
  logic [XW-1:0]       r_col, r_tag_x, r_h_x, r_t_x;
  logic [YW-1:0]       r_row, r_tag_y, r_h_y, r_t_y;
  logic [1:0]          r_count;
  logic [DATA_W-1:0]   r_h_data, r_t_data;

  logic                w_pop, w_issue, w_accept, w_col_wrap, w_last_issue, w_last_pop;
  logic [2:0]          w_occ;
  logic [5:0]          w_frame;
  logic [XW-1:0]       w_nxt_col;
  logic [ADDR_W-1:0]   w_nxt_row_off, w_nxt_addr, w_base, w_start_addr;

  assign w_pop        = (r_count != 2'd0) && i_pix_ready;
  // Occupancy after this edge's push/pop; issuing is allowed only if it stays below 2.
  assign w_occ        = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue      = (r_state == S_FETCH) && (w_occ < 3'd2);
  assign w_accept     = i_start && !r_busy && !r_done;
  assign w_col_wrap   = (r_col == COL_LAST);
  assign w_last_issue = w_col_wrap && (r_row == ROW_LAST);
  assign w_last_pop   = (r_state == S_DRAIN) && w_pop && (r_count == 2'd1) && !r_inflight;

  assign w_frame       = (i_frame_idx > LAST_F) ? LAST_F : i_frame_idx;
  assign w_base        = ADDR_W'(w_frame) * ADDR_W'(FRAME_W);
  assign w_start_addr  = w_base + ADDR_W'(i_hflip ? COL_LAST : '0);
  assign w_nxt_col     = w_col_wrap ? '0 : r_col + 1'b1;
  assign w_nxt_row_off = w_col_wrap ? r_row_off + SHEET : r_row_off;
  assign w_nxt_addr    = w_nxt_row_off + r_base + ADDR_W'(r_hflip ? COL_LAST - w_nxt_col : w_nxt_col);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hflip    <= 1'b0;
      r_inflight <= 1'b0;
      r_addr     <= '0;
      r_base     <= '0;
      r_row_off  <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_tag_x    <= '0;
      r_tag_y    <= '0;
      r_count    <= 2'd0;
      r_h_data   <= '0;
      r_h_x      <= '0;
      r_h_y      <= '0;
      r_t_data   <= '0;
      r_t_x      <= '0;
      r_t_y      <= '0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_x <= r_col;
        r_tag_y <= r_row;
      end

      // RAM data is valid in the cycle after an issue; tags carry the logical position.
      case (r_count)
        2'd0: begin
          if (r_inflight) begin
            r_h_data <= i_ram_data;
            r_h_x    <= r_tag_x;
            r_h_y    <= r_tag_y;
            r_count  <= 2'd1;
          end
        end
        2'd1: begin
          if (r_inflight && w_pop) begin
            r_h_data <= i_ram_data;
            r_h_x    <= r_tag_x;
            r_h_y    <= r_tag_y;
          end else if (r_inflight) begin
            r_t_data <= i_ram_data;
            r_t_x    <= r_tag_x;
            r_t_y    <= r_tag_y;
            r_count  <= 2'd2;
          end else if (w_pop) begin
            r_count  <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_h_data <= r_t_data;
            r_h_x    <= r_t_x;
            r_h_y    <= r_t_y;
            r_count  <= 2'd1;
          end
        end
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_FETCH;
            r_busy    <= 1'b1;
            r_hflip   <= i_hflip;
            r_base    <= w_base;
            r_row_off <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= w_start_addr;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_col     <= w_nxt_col;
            r_row_off <= w_nxt_row_off;
            if (w_col_wrap) r_row <= r_row + 1'b1;
            if (w_last_issue) r_state <= S_DRAIN;
            else              r_addr  <= w_nxt_addr;
          end
        end
        S_DRAIN: begin
          if (w_last_pop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_read_address = r_addr;
  assign o_pix_valid    = (r_count != 2'd0);
  assign o_pix_data     = r_h_data;
  assign o_pix_x        = r_h_x;
  assign o_pix_y        = r_h_y;
  assign o_pix_opaque   = (r_count != 2'd0) && (r_h_data != TRANSP_V);

endmodule

// File: tb/tb_sprite_frame_reader.sv
// tb/tb_sprite_frame_reader.sv - directed table-driven bench for sprite_frame_reader
// Small frame geometry (4x2 in a 16-wide sheet) so address sequences are hand-checkable.
module tb_sprite_frame_reader;
  localparam int AW = 18, DW = 4, FW = 4, FH = 2, SW = 16, NF = 4;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, hflip = 1'b0, ready = 1'b1;
  logic [5:0]    idx = 6'd0;
  logic          busy, done, valid, opaque;
  logic [AW-1:0] addr;
  logic [DW-1:0] ram_q, pdata;
  logic [1:0]    px;
  logic [0:0]    py;
  logic [DW-1:0] mem [64];

  int total = 0;
  int bad   = 0;

  sprite_frame_reader #(
    .ADDR_W(AW), .DATA_W(DW), .FRAME_W(FW), .FRAME_H(FH),
    .SHEET_W(SW), .NUM_FRAMES(NF), .TRANSP(0)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_frame_idx(idx), .i_hflip(hflip),
    .o_busy(busy), .o_done(done), .o_read_address(addr), .i_ram_data(ram_q),
    .o_pix_data(pdata), .o_pix_x(px), .o_pix_y(py), .o_pix_opaque(opaque),
    .o_pix_valid(valid), .i_pix_ready(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[addr[5:0]];

  typedef struct {
    logic [5:0] idx;
    logic       hflip;
    logic       rnd;
    logic       inj;
    int         addrs [8];
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input int vi);
    int k, cyc, a, dones;
    logic stall;
    logic [DW-1:0] sd;
    logic [1:0] sx;
    logic [0:0] sy;
    @(negedge clk);
    start = 1'b1; idx = vecs[vi].idx; hflip = vecs[vi].hflip; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d first_addr", vi), int'(addr), vecs[vi].addrs[0]);
    check($sformatf("v%0d busy_on", vi), int'(busy), 1);
    k = 0; cyc = 1; dones = 0; stall = 1'b0; sd = '0; sx = '0; sy = '0;
    while (k < 8 && cyc < 200) begin
      ready = vecs[vi].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = vecs[vi].inj && (cyc == 4);
      if (start) begin idx = 6'd1; hflip = ~vecs[vi].hflip; end
      if (done) dones++;
      if (stall) begin
        check($sformatf("v%0d stall_valid", vi), int'(valid), 1);
        check($sformatf("v%0d stall_data", vi), int'(pdata), int'(sd));
        check($sformatf("v%0d stall_xy", vi), int'({px, py}), int'({sx, sy}));
      end
      if (valid && ready) begin
        a = vecs[vi].addrs[k];
        check($sformatf("v%0d p%0d data", vi, k), int'(pdata), int'(mem[a]));
        check($sformatf("v%0d p%0d x", vi, k), int'(px), k % 4);
        check($sformatf("v%0d p%0d y", vi, k), int'(py), k / 4);
        check($sformatf("v%0d p%0d opaque", vi, k), int'(opaque), (mem[a] != 0) ? 1 : 0);
        if (!vecs[vi].rnd) check($sformatf("v%0d p%0d cycle", vi, k), cyc, 3 + k);
        k++;
        stall = 1'b0;
      end else begin
        stall = valid;
        sd = pdata; sx = px; sy = py;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check($sformatf("v%0d handshakes", vi), k, 8);
    check($sformatf("v%0d early_done", vi), dones, 0);
    check($sformatf("v%0d done_pulse", vi), int'(done), 1);
    check($sformatf("v%0d busy_off", vi), int'(busy), 0);
    check($sformatf("v%0d valid_off", vi), int'(valid), 0);
    // A start coinciding with done must be ignored.
    start = 1'b1; idx = 6'd2;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d done_once", vi), int'(done), 0);
    check($sformatf("v%0d start_at_done_ignored", vi), int'(busy), 0);
  endtask

  initial begin
    int k, n;
    for (int i = 0; i < 64; i++) mem[i] = DW'((i % 15) + 1);
    mem[5] = '0;

    vecs[0].idx = 6'd1; vecs[0].hflip = 1'b0; vecs[0].rnd = 1'b0; vecs[0].inj = 1'b0;
    vecs[0].addrs = '{4, 5, 6, 7, 20, 21, 22, 23};
    vecs[1].idx = 6'd0; vecs[1].hflip = 1'b1; vecs[1].rnd = 1'b0; vecs[1].inj = 1'b0;
    vecs[1].addrs = '{3, 2, 1, 0, 19, 18, 17, 16};
    vecs[2].idx = 6'd2; vecs[2].hflip = 1'b0; vecs[2].rnd = 1'b1; vecs[2].inj = 1'b0;
    vecs[2].addrs = '{8, 9, 10, 11, 24, 25, 26, 27};
    vecs[3].idx = 6'd7; vecs[3].hflip = 1'b0; vecs[3].rnd = 1'b0; vecs[3].inj = 1'b1;
    vecs[3].addrs = '{12, 13, 14, 15, 28, 29, 30, 31};
    vecs[4].idx = 6'd3; vecs[4].hflip = 1'b1; vecs[4].rnd = 1'b1; vecs[4].inj = 1'b0;
    vecs[4].addrs = '{15, 14, 13, 12, 31, 30, 29, 28};

    #12;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset valid", int'(valid), 0);
    check("reset addr", int'(addr), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted after three pixels of a frame.
    @(negedge clk);
    start = 1'b1; idx = 6'd1; hflip = 1'b0; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; n = 0;
    while (k < 3 && n < 50) begin
      if (valid && ready) k++;
      @(negedge clk);
      n++;
    end
    check("midreset pixels_before", k, 3);
    rst = 1'b1;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset valid", int'(valid), 0);
    check("midreset addr", int'(addr), 0);
    check("midreset pix_xy", int'({px, py}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset idle valid", int'(valid), 0);

    for (int v = 0; v < 5; v++) run_frame(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
